bird_physics: RTL
=================

Name: bird_physics

Overview:
- Vertical-motion engine for the bird inside NERP_demo_top.
- Sits downstream of the flap button conditioner and upstream of the VGA renderer and pipe/collision logic.
- Consumes one-cycle flap pulses, a once-per-frame tick and a collision flag.
- Produces the bird's Y position, its velocity and the game life-cycle state that the renderer and the score logic consume.

Parameters:
- Y_W, 10, width of Y coordinate (visible rows 0..479).
- V_W, 6, width of signed velocity (pixels/frame).
- Y_START, 232, hover/restart row.
- Y_MIN, 0, ceiling row; clamp only, not fatal.
- Y_MAX, 464, floor row (480 minus bird height 16); reaching it ends the game.
- GRAVITY, 1, velocity increment per frame.
- FLAP_VEL, -6, velocity loaded on flap (signed).
- VMAX, 8, terminal downward velocity.

Ports:
- clk  in  1  system clock, 100 MHz.
- clr_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per frame (vsync-derived).
- flap_pulse  in  1  one-cycle debounced flap request.
- pause  in  1  level; freezes motion.
- hit  in  1  level from pipe collision logic.
- bird_y  out  Y_W  current top row of bird.
- bird_vel  out  V_W  signed current velocity.
- state  out  2  READY=0, FLY=1, DEAD_FALL=2, OVER=3.
- alive  out  1  high in READY and FLY; gates pipe scrolling and scoring.
- game_over  out  1  high only in OVER.

Behaviour:
- Reset: clk is the only clock; clr_n is asynchronous, active-low. While clr_n is low: bird_y=Y_START, bird_vel=0, state=READY, alive=1, game_over=0, flap_pending=0.
- All outputs are registered. Updates appear the cycle after the qualifying frame_tick or flap_pulse edge.
- Flap latch:
  - flap_pulse sets flap_pending.
  - flap_pending is consumed, and cleared, on the next non-paused frame_tick.
  - If flap_pulse and frame_tick coincide, the flap applies on that tick.
  - flap_pulse is discarded while pause=1, in DEAD_FALL and in OVER (OVER uses it directly; see below).
- Pause: frame_tick is ignored and all registers hold. flap_pending is held, not cleared.
- READY:
  - bird_y=Y_START, bird_vel=0; frame_tick has no effect without a pending flap.
  - A tick with flap_pending loads bird_vel=FLAP_VEL, sets bird_y=Y_START+FLAP_VEL and moves to FLY.
- FLY, per tick:
  - v_next = FLAP_VEL if flap_pending, else min(bird_vel+GRAVITY, VMAX).
  - y_next = bird_y + v_next, computed signed at Y_W+2 bits.
  - If y_next <= Y_MIN: bird_y=Y_MIN, bird_vel=0.
  - If y_next >= Y_MAX: bird_y=Y_MAX, bird_vel=0, go to OVER.
  - Otherwise store both values.
- hit in FLY:
  - Next clock (no tick needed): go to DEAD_FALL. bird_vel becomes 0 if negative, else is held.
  - hit and a floor-reaching tick in the same cycle: OVER wins.
  - hit is ignored in every other state.
- DEAD_FALL: each tick applies gravity with no flaps, using the same clamps as FLY. Reaching Y_MAX goes to OVER.
- OVER:
  - Outputs are frozen.
  - flap_pulse (paused or not) goes to READY with bird_y=Y_START, bird_vel=0 and flap_pending cleared. That flap does not also launch the bird.
- Velocity saturates at VMAX and never goes below FLAP_VEL. bird_y never leaves [Y_MIN, Y_MAX].
- Reset asserted mid-operation forces the reset values immediately, with no clock required.

Decomposition:
- Shared package flappy_pkg holds:
  - the state encoding typedef (READY/FLY/DEAD_FALL/OVER);
  - the screen constants (visible 640x480, bird height 16) from which Y_MAX defaults are derived.
- One natural sub-module: bird_integrator.
  - Combinational: bird_y, bird_vel, flap, gravity_only in; clamped y_next, v_next, floor_hit, ceil_hit out.
  - The FSM and flap latch stay in bird_physics.

Test Plan:
- Reset and launch:
  - clr_n low for 100 ns, then high -> bird_y=232, bird_vel=0, state=READY, alive=1.
  - Then flap_pulse plus tick -> FLY, bird_vel=-6, bird_y=226.
  - Next tick, no flap -> bird_vel=-5, bird_y=221.
- Free fall and terminal velocity: from FLY at y=232, vel=0, 8 ticks -> vel steps 1..8, bird_y=268; one more tick -> bird_y=276, vel stays 8.
- Ceiling clamp: FLY at y=4, flap plus tick -> bird_y=0, bird_vel=0, state remains FLY.
- Floor and restart:
  - FLY at y=460, vel=8, tick -> bird_y=464, state=OVER, game_over=1, alive=0.
  - Then flap_pulse -> READY, bird_y=232, no launch.
- Collision:
  - FLY, vel=-3, hit=1 -> next cycle DEAD_FALL, vel=0, alive=0.
  - Flaps during descent have no effect.
  - Ticks continue until bird_y=464, state=OVER.
- Pause and async reset:
  - pause=1 over 5 ticks with a flap mid-pause -> bird_y/bird_vel unchanged.
  - Unpause and tick -> gravity applied, not flap.
  - clr_n low mid-fall between clock edges -> bird_y=232 immediately.

Source files
------------

// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flappy_pkg
// Description : Shared game state encoding and screen geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

   typedef enum logic [1:0] {
      READY     = 2'd0,
      FLY       = 2'd1,
      DEAD_FALL = 2'd2,
      OVER      = 2'd3
   } bird_state_t;

   localparam int c_screen_w  = 640;
   localparam int c_screen_h  = 480;
   localparam int c_bird_h    = 16;
   // Lowest row the bird's top edge may reach while fully on screen.
   localparam int c_y_max_def = c_screen_h - c_bird_h;

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/bird_integrator.sv
`default_nettype none
// ============================================================================
// Module      : bird_integrator
// Description : One-frame velocity/position step with ceiling and floor clamps.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_integrator
   import flappy_pkg::*;
#(
   parameter int Y_W      = 10,
   parameter int V_W      = 6,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = c_y_max_def,
   parameter int GRAVITY  = 1,
   parameter int FLAP_VEL = -6,
   parameter int VMAX     = 8
) (
   input  logic        [Y_W-1:0] bird_y,
   input  logic signed [V_W-1:0] bird_vel,
   input  logic                  flap,
   input  logic                  gravity_only,
   output logic        [Y_W-1:0] y_next,
   output logic signed [V_W-1:0] v_next,
   output logic                  floor_hit,
   output logic                  ceil_hit
);

   localparam int c_s_w = Y_W + 2;

   logic signed [V_W:0]   w_v_grav;
   logic signed [V_W-1:0] w_v_raw;
   logic signed [c_s_w-1:0] w_y_sum;

   always_comb begin
      // One extra bit so VMAX+GRAVITY cannot wrap before saturation.
      w_v_grav = (V_W+1)'(bird_vel) + (V_W+1)'(GRAVITY);
      if (flap && !gravity_only) begin
         w_v_raw = V_W'(FLAP_VEL);
      end else if (w_v_grav > (V_W+1)'(VMAX)) begin
         w_v_raw = V_W'(VMAX);
      end else begin
         w_v_raw = w_v_grav[V_W-1:0];
      end

      w_y_sum   = $signed({2'b00, bird_y}) + c_s_w'(w_v_raw);
      y_next    = w_y_sum[Y_W-1:0];
      v_next    = w_v_raw;
      floor_hit = 1'b0;
      ceil_hit  = 1'b0;
      if (w_y_sum <= c_s_w'(Y_MIN)) begin
         y_next   = Y_W'(Y_MIN);
         v_next   = '0;
         ceil_hit = 1'b1;
      end else if (w_y_sum >= c_s_w'(Y_MAX)) begin
         y_next    = Y_W'(Y_MAX);
         v_next    = '0;
         floor_hit = 1'b1;
      end
   end

endmodule : bird_integrator
`default_nettype wire

// File: rtl/bird_physics.sv
`default_nettype none
// ============================================================================
// Module      : bird_physics
// Description : Bird vertical motion, flap latch and game life-cycle FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_physics
   import flappy_pkg::*;
#(
   parameter int Y_W      = 10,
   parameter int V_W      = 6,
   parameter int Y_START  = 232,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = c_y_max_def,
   parameter int GRAVITY  = 1,
   parameter int FLAP_VEL = -6,
   parameter int VMAX     = 8
) (
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic                  frame_tick,
   input  logic                  flap_pulse,
   input  logic                  pause,
   input  logic                  hit,
   output logic        [Y_W-1:0] bird_y,
   output logic signed [V_W-1:0] bird_vel,
   output logic [1:0]            state,
   output logic                  alive,
   output logic                  game_over
);

   bird_state_t           r_state, w_state;
   logic        [Y_W-1:0] r_y, w_y;
   logic signed [V_W-1:0] r_vel, w_vel;
   logic                  r_pend, w_pend;
   logic                  r_alive, r_game_over;

   logic                  w_tick, w_flap_live, w_flap;
   logic        [Y_W-1:0] w_int_y;
   logic signed [V_W-1:0] w_int_v;
   logic                  w_floor, w_ceil;

   assign w_tick      = frame_tick && !pause;
   assign w_flap_live = flap_pulse && !pause;
   // A flap arriving with the tick counts on that same tick.
   assign w_flap      = r_pend || w_flap_live;

   bird_integrator #(
      .Y_W      (Y_W),
      .V_W      (V_W),
      .Y_MIN    (Y_MIN),
      .Y_MAX    (Y_MAX),
      .GRAVITY  (GRAVITY),
      .FLAP_VEL (FLAP_VEL),
      .VMAX     (VMAX)
   ) u_integrator (
      .bird_y       (r_y),
      .bird_vel     (r_vel),
      .flap         (w_flap),
      .gravity_only (r_state == DEAD_FALL),
      .y_next       (w_int_y),
      .v_next       (w_int_v),
      .floor_hit    (w_floor),
      .ceil_hit     (w_ceil)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state     <= READY;
         r_y         <= Y_W'(Y_START);
         r_vel       <= '0;
         r_pend      <= 1'b0;
         r_alive     <= 1'b1;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_y         <= w_y;
         r_vel       <= w_vel;
         r_pend      <= w_pend;
         r_alive     <= (w_state == READY) || (w_state == FLY);
         r_game_over <= (w_state == OVER);
      end
   end

   always_comb begin
      w_state = r_state;
      w_y     = r_y;
      w_vel   = r_vel;
      w_pend  = r_pend;
      case (r_state)
         READY: begin
            if (w_tick && w_flap) begin
               w_state = FLY;
               w_y     = w_int_y;
               w_vel   = w_int_v;
               w_pend  = 1'b0;
            end else if (w_flap_live) begin
               w_pend = 1'b1;
            end
         end
         FLY: begin
            if (w_tick) begin
               w_y    = w_int_y;
               w_vel  = w_int_v;
               w_pend = 1'b0;
               if (w_floor) w_state = OVER;
            end else if (w_flap_live) begin
               w_pend = 1'b1;
            end
            // Collision takes effect without a tick, but a floor landing wins.
            if (hit && !pause && !(w_tick && w_floor)) begin
               w_state = DEAD_FALL;
               w_pend  = 1'b0;
               if (w_vel[V_W-1]) w_vel = '0;
            end
         end
         DEAD_FALL: begin
            if (w_tick) begin
               w_y   = w_int_y;
               w_vel = w_int_v;
               if (w_floor || w_ceil && 1'b0) w_state = OVER;
            end
         end
         OVER: begin
            if (flap_pulse) begin
               w_state = READY;
               w_y     = Y_W'(Y_START);
               w_vel   = '0;
               w_pend  = 1'b0;
            end
         end
         default: w_state = READY;
      endcase
   end

   assign bird_y    = r_y;
   assign bird_vel  = r_vel;
   assign state     = r_state;
   assign alive     = r_alive;
   assign game_over = r_game_over;

endmodule : bird_physics
`default_nettype wire
